// File: rtl/soc_axi_txn_limiter.sv
// rtl/soc_axi_txn_limiter.sv - per-port AXI outstanding-transaction limiter with drain and error flags
package soc_pkg;
  typedef struct packed {
    logic [3:0] id;
    logic [7:0] addr;
    logic [7:0] len;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } m_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } m_resp_t;
endpackage

module soc_axi_txn_limiter #(
  parameter int unsigned MAX_W_TXN = 4,
  parameter int unsigned MAX_R_TXN = 4,
  parameter int unsigned CNT_W = $clog2(((MAX_W_TXN > MAX_R_TXN) ? MAX_W_TXN : MAX_R_TXN) + 1),
  parameter type req_t = soc_pkg::m_req_t,
  parameter type resp_t = soc_pkg::m_resp_t
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             drain_i,
  input  req_t             slv_req_i,
  output resp_t            slv_resp_o,
  output req_t             mst_req_o,
  input  resp_t            mst_resp_i,
  output logic [CNT_W-1:0] w_cnt_o,
  output logic [CNT_W-1:0] r_cnt_o,
  output logic             idle_o,
  output logic [1:0]       err_o
);

  if (MAX_W_TXN < 1 || MAX_W_TXN > 255) begin : g_bad_max_w
    $error("MAX_W_TXN must be in 1..255");
  end
  if (MAX_R_TXN < 1 || MAX_R_TXN > 255) begin : g_bad_max_r
    $error("MAX_R_TXN must be in 1..255");
  end

  localparam logic [CNT_W-1:0] MaxW = CNT_W'(MAX_W_TXN);
  localparam logic [CNT_W-1:0] MaxR = CNT_W'(MAX_R_TXN);
  localparam logic [CNT_W-1:0] One  = CNT_W'(1);

  logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [1:0]       err_q, err_d;
  logic             aw_block, ar_block;
  logic             aw_inc, b_dec, ar_inc, r_dec;

  // Block decision uses only registered counts and drain, never downstream ready.
  assign aw_block = drain_i | (w_cnt_q == MaxW);
  assign ar_block = drain_i | (r_cnt_q == MaxR);

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    if (aw_block) begin
      mst_req_o.aw_valid  = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
    end
    if (ar_block) begin
      mst_req_o.ar_valid  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
    end
  end

  assign aw_inc = slv_req_i.aw_valid & ~aw_block & mst_resp_i.aw_ready;
  assign b_dec  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign ar_inc = slv_req_i.ar_valid & ~ar_block & mst_resp_i.ar_ready;
  assign r_dec  = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  always_comb begin
    w_cnt_d = w_cnt_q;
    r_cnt_d = r_cnt_q;
    err_d   = err_q;
    if (aw_inc && !b_dec) begin
      w_cnt_d = w_cnt_q + One;
    end else if (b_dec && !aw_inc) begin
      if (w_cnt_q == '0) err_d[0] = 1'b1;
      else               w_cnt_d = w_cnt_q - One;
    end
    if (ar_inc && !r_dec) begin
      r_cnt_d = r_cnt_q + One;
    end else if (r_dec && !ar_inc) begin
      if (r_cnt_q == '0) err_d[1] = 1'b1;
      else               r_cnt_d = r_cnt_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_cnt_q <= '0;
      r_cnt_q <= '0;
      err_q   <= '0;
    end else begin
      w_cnt_q <= w_cnt_d;
      r_cnt_q <= r_cnt_d;
      err_q   <= err_d;
    end
  end

  assign w_cnt_o = w_cnt_q;
  assign r_cnt_o = r_cnt_q;
  assign err_o   = err_q;
  assign idle_o  = (w_cnt_q == '0) && (r_cnt_q == '0);

endmodule
